mem_access_unit: RTL

//  Load/store stage directly downstream of the ALU: takes the ALU result as effective address plus rs2 store data.

---
 rtl/mem_access_unit_pkg.sv | 53 +++++
 rtl/mem_access_unit_load_extend.sv | 27 ++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store stage: FSM states, RV32 funct3 width codes, lane helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Anything that is not a recognised byte/half code is a word access.
  function automatic size_e access_size(input logic is_store, input logic [2:0] funct3);
    size_e sz;
    sz = SZ_W;
    if (funct3 == F3_B || (!is_store && funct3 == F3_BU)) begin
      sz = SZ_B;
    end else if (funct3 == F3_H || (!is_store && funct3 == F3_HU)) begin
      sz = SZ_H;
    end
    return sz;
  endfunction

  function automatic logic [1:0] lane_offset(input size_e sz, input logic [1:0] lo);
    logic [1:0] off;
    case (sz)
      SZ_B:    off = lo;
      SZ_H:    off = {lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
    logic mis;
    case (sz)
      SZ_H:    mis = lo[0];
      SZ_W:    mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load lane select plus sign/zero extension of the returned bus word.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  size_e       sz;
  logic [15:0] shifted;
  logic        sext;

  always_comb begin
    sz      = access_size(1'b0, funct3);
    shifted = 16'(rdata >> {lane_offset(sz, addr_lo), 3'b000});
    sext    = ~funct3[2];
    data    = rdata;
    case (sz)
      SZ_B:    data = {{24{sext & shifted[7]}}, shifted[7:0]};
      SZ_H:    data = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store stage: IDLE -> BUS -> RESP, lane-steered stores, extended loads.
// Build option MEM_ACCESS_MISALIGN_TRAP_EN: misaligned accesses skip the bus and return resp_fault.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [RD_WIDTH-1:0]   req_rd,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [RD_WIDTH-1:0]   resp_rd,
  output logic                  resp_fault
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            lo_q, lo_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic [RD_WIDTH-1:0]   rd_q, rd_d;
  logic                  fault_q, fault_d;

  size_e       req_sz;
  logic [1:0]  req_off;
  logic        req_trap;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata_lane;
  logic [31:0] ext_data;

  assign req_sz  = access_size(req_is_store, req_funct3);
  assign req_off = lane_offset(req_sz, req_addr[1:0]);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign req_trap = misaligned(req_sz, req_addr[1:0]);
`else
  assign req_trap = 1'b0;
`endif

  always_comb begin
    req_wstrb      = 4'b1111;
    req_wdata_lane = req_wdata;
    case (req_sz)
      SZ_B: begin
        req_wstrb      = 4'b0001 << req_off;
        req_wdata_lane = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        req_wstrb      = 4'b0011 << req_off;
        req_wdata_lane = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  mem_access_unit_load_extend u_load_extend (
    .rdata   (mem_rdata),
    .addr_lo (lo_q),
    .funct3  (funct3_q),
    .data    (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    lo_d        = lo_q;
    resp_data_d = resp_data_q;
    rd_d        = rd_q;
    fault_d     = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d      = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          we_d        = req_is_store & ~req_trap;
          wstrb_d     = (req_is_store && !req_trap) ? req_wstrb : 4'b0000;
          wdata_d     = req_wdata_lane;
          funct3_d    = req_funct3;
          lo_d        = req_addr[1:0];
          rd_d        = req_rd;
          fault_d     = req_trap;
          resp_data_d = 32'h0;
          // A trapped access never reaches the bus.
          state_d     = req_trap ? ST_RESP : ST_BUS;
        end
      end
      ST_BUS: begin
        if (mem_ready) begin
          resp_data_d = we_q ? 32'h0 : ext_data;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= 32'h0;
      funct3_q    <= 3'b000;
      lo_q        <= 2'b00;
      resp_data_q <= 32'h0;
      rd_q        <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      lo_q        <= lo_d;
      resp_data_q <= resp_data_d;
      rd_q        <= rd_d;
      fault_q     <= fault_d;
    end
  end

  // Handshake outputs decode the state directly so an async reset withdraws mem_valid at once.
  assign req_ready  = (state_q == ST_IDLE);
  assign mem_valid  = (state_q == ST_BUS);
  assign resp_valid = (state_q == ST_RESP);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_wdata  = wdata_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = rd_q;
  assign resp_fault = fault_q;

endmodule
